multi_data_sync: RTL and testbench
==================================

MULTI_DATA_SYNC -- requirements
Module: multi_data_sync

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 2, meaning synchronizer flop count per channel (legal range 2..4).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning data bits per channel.
REQ-003 The block SHALL have parameter NUM_CH, default 2, meaning independent channel count (1..8).
REQ-004 The block SHALL have parameter EN_MODE, default 0, meaning 0 = level enable (rising edge starts a transfer), 1 = toggle enable (any edge starts a transfer).
REQ-005 The block SHALL have port CLK, input, 1, sole clock; one clock, all logic on its rising edge.
REQ-006 The block SHALL have port Reset, input, 1, reset, synchronous and active-low.
REQ-007 The block SHALL have port Async_bus, input, NUM_CH*WIDTH, source data; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-008 The block SHALL have port bus_EN, input, NUM_CH, asynchronous per-channel enable.
REQ-009 The block SHALL have port Ready, input, NUM_CH, consumer accepts held data.
REQ-010 The block SHALL have port Ovr_clr, input, NUM_CH, clears the sticky overrun flag.
REQ-011 The block SHALL have port sync_bus, output, NUM_CH*WIDTH, captured data, same channel packing as Async_bus.
REQ-012 The block SHALL have port EN_pulse, output, NUM_CH, one-cycle capture strobe.
REQ-013 The block SHALL have port Valid, output, NUM_CH, data held awaiting Ready.
REQ-014 The block SHALL have port Ack, output, NUM_CH, last synchronizer stage, returned to the source for a 4-phase handshake.
REQ-015 The block SHALL have port Overrun, output, NUM_CH, sticky: a transfer was dropped.

Function
REQ-016 Each channel SHALL pass bus_EN through NUM_STAGES flops in series; Ack SHALL equal the last stage.
REQ-017 The edge detector SHALL compare the last stage with one further flop: EN_MODE=0 detects 0->1; EN_MODE=1 detects any change.
REQ-018 Latency: bus_EN changing before edge k SHALL give EN_pulse high for exactly one cycle after edge k+NUM_STAGES.
REQ-019 A channel SHALL load sync_bus from Async_bus only on a detect cycle that is not dropped; otherwise sync_bus SHALL hold.
REQ-020 Per channel, the FSM SHALL have IDLE (Valid=0) and HOLD (Valid=1).
REQ-021 IDLE + detect -> HOLD: capture data, EN_pulse=1.
REQ-022 HOLD + Ready=1 + no detect -> IDLE.
REQ-023 HOLD + Ready=1 + detect -> stay in HOLD: capture new data, EN_pulse=1, no overrun.
REQ-024 HOLD + Ready=0 + detect -> stay in HOLD: keep old data, EN_pulse=0, Overrun set.
REQ-025 Ready SHALL be ignored in IDLE.
REQ-026 Overrun SHALL clear on Ovr_clr=1; a same-cycle new overrun SHALL win and leave it set.
REQ-027 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.

Reset
REQ-028 While Reset=0 at a clock edge, all sync flops, the edge flop, sync_bus, EN_pulse, Valid, Ack and Overrun SHALL become 0 and the FSM SHALL enter IDLE.
REQ-029 A reset asserted mid-transfer SHALL drop that transfer with no EN_pulse afterwards; in EN_MODE=1, a bus_EN level of 1 held across reset SHALL produce one detect NUM_STAGES+1 edges after release.

Configuration
REQ-030 With macro DATA_SYNC_PARITY_EN defined, the block SHALL add input Async_par[NUM_CH] (even parity of the channel's data) and output Par_err[NUM_CH].
REQ-031 Par_err SHALL be registered on the capture edge, cleared by Reset, and updated only on capture cycles.
REQ-032 Par_err SHALL flag a parity mismatch on the captured word; the data SHALL still be captured.
REQ-033 Without DATA_SYNC_PARITY_EN, neither port nor any parity logic SHALL exist.

Structure
REQ-034 Package multi_data_sync_pkg SHALL hold the FSM state enum (IDLE, HOLD) and the EN_MODE constants (EN_LEVEL=0, EN_TOGGLE=1).
REQ-035 Sub-module sync_channel SHALL implement one channel (sync chain, edge detect, FSM, data register, overrun); the top SHALL generate NUM_CH instances and do the bus slicing only.

Verification
REQ-036 Latency: NUM_STAGES=2, EN_MODE=0, ch0 data 0xA5, bus_EN[0] 0->1 -> EN_pulse[0] high one cycle 3 edges later, sync_bus[7:0]=0xA5, Valid[0]=1, Ack[0]=1 from edge 2.
REQ-037 Accept then idle: Ready[0]=1 on the cycle after capture -> Valid[0]=0 next cycle; sync_bus[7:0] stays 0xA5.
REQ-038 Overrun: EN_MODE=1, ch1 captures 0x3C, Ready[1]=0, ch1 toggles again with 0x7E -> sync_bus[15:8]=0x3C, EN_pulse[1]=0, Overrun[1]=1; Ovr_clr[1]=1 -> 0.
REQ-039 Back-to-back: Ready=1 on the same cycle as a new detect -> Valid stays 1, data becomes the new word, Overrun stays 0.
REQ-040 Reset mid-sync: Reset=0 one cycle after bus_EN rises -> all outputs 0, no EN_pulse after release (EN_MODE=0, bus_EN returned to 0).
REQ-041 Parity (macro defined): ch0 data 0x01 with Async_par=0 -> Par_err[0]=1 on capture; data 0x03 with Async_par=0 -> Par_err[0]=0.

Source files
------------

// File: rtl/multi_data_sync_pkg.sv
// rtl/multi_data_sync_pkg.sv - shared types and enable-mode constants for multi_data_sync.
// Optional parity feature is enabled elsewhere by DATA_SYNC_PARITY_EN.
package multi_data_sync_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } ch_state_e;

    localparam int EN_LEVEL  = 0;
    localparam int EN_TOGGLE = 1;

    // Level mode starts a transfer on 0->1 only; toggle mode on any change.
    function automatic logic en_detect(input int mode, input logic cur, input logic prev);
        return (mode == EN_TOGGLE) ? (cur ^ prev) : (cur & ~prev);
    endfunction

endpackage

// File: rtl/sync_channel.sv
// rtl/sync_channel.sv - one channel: enable synchronizer, edge detect, hold FSM, data and overrun.
// Parity checking is present only with DATA_SYNC_PARITY_EN defined.
module sync_channel
    import multi_data_sync_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int WIDTH      = 8,
    parameter int EN_MODE    = EN_LEVEL
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    input  logic             ovr_clr_i,
`ifdef DATA_SYNC_PARITY_EN
    input  logic             par_i,
    output logic             par_err_o,
`endif
    output logic [WIDTH-1:0] data_o,
    output logic             pulse_o,
    output logic             valid_o,
    output logic             ack_o,
    output logic             overrun_o
);

    logic [NUM_STAGES-1:0] sync_q;
    logic                  edge_q;
    ch_state_e             state_q;
    logic [WIDTH-1:0]      data_q;
    logic                  pulse_q;
    logic                  valid_q;
    logic                  ovr_q;
    logic                  ovr_d;
    logic                  detect;
    logic                  capture;
    logic                  drop;

    assign detect  = en_detect(EN_MODE, sync_q[NUM_STAGES-1], edge_q);
    // A detect while the consumer still holds old data is dropped, not captured.
    assign capture = detect && ((state_q == IDLE) || ready_i);
    assign drop    = detect && (state_q == HOLD) && !ready_i;
    assign ovr_d   = drop | (ovr_q & ~ovr_clr_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], en_i};
            edge_q <= sync_q[NUM_STAGES-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            pulse_q <= capture;
            ovr_q   <= ovr_d;
            if (capture) begin
                data_q <= data_i;
            end
            case (state_q)
                IDLE: begin
                    if (detect) begin
                        state_q <= HOLD;
                        valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (ready_i && !detect) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef DATA_SYNC_PARITY_EN
    logic par_err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            par_err_q <= 1'b0;
        end else if (capture) begin
            par_err_q <= (^data_i) ^ par_i;
        end
    end

    assign par_err_o = par_err_q;
`endif

    assign data_o    = data_q;
    assign pulse_o   = pulse_q;
    assign valid_o   = valid_q;
    assign ack_o     = sync_q[NUM_STAGES-1];
    assign overrun_o = ovr_q;

endmodule

// File: rtl/multi_data_sync.sv
// rtl/multi_data_sync.sv - NUM_CH independent enable-qualified data synchronizers.
// Defining DATA_SYNC_PARITY_EN adds Async_par / Par_err.
module multi_data_sync
    import multi_data_sync_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int WIDTH      = 8,
    parameter int NUM_CH     = 2,
    parameter int EN_MODE    = EN_LEVEL
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic [NUM_CH*WIDTH-1:0] Async_bus,
    input  logic [NUM_CH-1:0]       bus_EN,
    input  logic [NUM_CH-1:0]       Ready,
    input  logic [NUM_CH-1:0]       Ovr_clr,
`ifdef DATA_SYNC_PARITY_EN
    input  logic [NUM_CH-1:0]       Async_par,
    output logic [NUM_CH-1:0]       Par_err,
`endif
    output logic [NUM_CH*WIDTH-1:0] sync_bus,
    output logic [NUM_CH-1:0]       EN_pulse,
    output logic [NUM_CH-1:0]       Valid,
    output logic [NUM_CH-1:0]       Ack,
    output logic [NUM_CH-1:0]       Overrun
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sync_channel #(
            .NUM_STAGES(NUM_STAGES),
            .WIDTH     (WIDTH),
            .EN_MODE   (EN_MODE)
        ) u_ch (
            .clk_i     (CLK),
            .rst_ni    (Reset),
            .en_i      (bus_EN[c]),
            .data_i    (Async_bus[c*WIDTH +: WIDTH]),
            .ready_i   (Ready[c]),
            .ovr_clr_i (Ovr_clr[c]),
`ifdef DATA_SYNC_PARITY_EN
            .par_i     (Async_par[c]),
            .par_err_o (Par_err[c]),
`endif
            .data_o    (sync_bus[c*WIDTH +: WIDTH]),
            .pulse_o   (EN_pulse[c]),
            .valid_o   (Valid[c]),
            .ack_o     (Ack[c]),
            .overrun_o (Overrun[c])
        );
    end

endmodule

// File: tb/tb_multi_data_sync.sv
// tb/tb_multi_data_sync.sv - bench: level-mode (2 stages) and toggle-mode (3 stages) instances vs a model.
// Parity checks are added when DATA_SYNC_PARITY_EN is defined.
module tb_multi_data_sync;

    localparam int NS_A = 2;
    localparam int NS_B = 3;
    localparam int MODE_A = 0;
    localparam int MODE_B = 1;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [15:0] Async_bus;
    logic [1:0]  bus_EN;
    logic [1:0]  Ready;
    logic [1:0]  Ovr_clr;
    logic [1:0]  Async_par;

    logic [15:0] sb  [2];
    logic [1:0]  pls [2];
    logic [1:0]  vld [2];
    logic [1:0]  ack [2];
    logic [1:0]  ovr [2];
    logic [1:0]  perr [2];

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    always #5 CLK = ~CLK;

    multi_data_sync #(.NUM_STAGES(NS_A), .WIDTH(8), .NUM_CH(2), .EN_MODE(MODE_A)) dut_a (
        .CLK      (CLK),
        .Reset    (Reset),
        .Async_bus(Async_bus),
        .bus_EN   (bus_EN),
        .Ready    (Ready),
        .Ovr_clr  (Ovr_clr),
`ifdef DATA_SYNC_PARITY_EN
        .Async_par(Async_par),
        .Par_err  (perr[0]),
`endif
        .sync_bus (sb[0]),
        .EN_pulse (pls[0]),
        .Valid    (vld[0]),
        .Ack      (ack[0]),
        .Overrun  (ovr[0])
    );

    multi_data_sync #(.NUM_STAGES(NS_B), .WIDTH(8), .NUM_CH(2), .EN_MODE(MODE_B)) dut_b (
        .CLK      (CLK),
        .Reset    (Reset),
        .Async_bus(Async_bus),
        .bus_EN   (bus_EN),
        .Ready    (Ready),
        .Ovr_clr  (Ovr_clr),
`ifdef DATA_SYNC_PARITY_EN
        .Async_par(Async_par),
        .Par_err  (perr[1]),
`endif
        .sync_bus (sb[1]),
        .EN_pulse (pls[1]),
        .Valid    (vld[1]),
        .Ack      (ack[1]),
        .Overrun  (ovr[1])
    );

    // Model: hist[k] is bus_EN as sampled k+1 edges ago; a transfer starts at
    // edge t when the samples from NS and NS+1 edges earlier differ as the mode requires.
    logic       hist   [2][2][5];
    logic [7:0] m_data [2][2];
    logic       m_pulse[2][2];
    logic       m_valid[2][2];
    logic       m_ovr  [2][2];
    logic       m_perr [2][2];

    always @(posedge CLK) begin : model
        int   ns;
        int   mode;
        logic cur, prev, det, set_ovr;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (!Reset) begin
                    for (int k = 0; k < 5; k++) hist[i][c][k] = 1'b0;
                    m_data[i][c]  = 8'h00;
                    m_pulse[i][c] = 1'b0;
                    m_valid[i][c] = 1'b0;
                    m_ovr[i][c]   = 1'b0;
                    m_perr[i][c]  = 1'b0;
                end else begin
                    ns   = (i == 0) ? NS_A : NS_B;
                    mode = (i == 0) ? MODE_A : MODE_B;
                    cur  = hist[i][c][ns-1];
                    prev = hist[i][c][ns];
                    det  = (mode == 1) ? (cur != prev) : (cur && !prev);
                    set_ovr = 1'b0;
                    if (det && (!m_valid[i][c] || Ready[c])) begin
                        m_data[i][c]  = Async_bus[c*8 +: 8];
                        m_perr[i][c]  = (^Async_bus[c*8 +: 8]) ^ Async_par[c];
                        m_pulse[i][c] = 1'b1;
                        m_valid[i][c] = 1'b1;
                    end else begin
                        m_pulse[i][c] = 1'b0;
                        if (det) set_ovr = 1'b1;
                        else if (m_valid[i][c] && Ready[c]) m_valid[i][c] = 1'b0;
                    end
                    m_ovr[i][c] = set_ovr | (m_ovr[i][c] & ~Ovr_clr[c]);
                    for (int k = 4; k > 0; k--) hist[i][c][k] = hist[i][c][k-1];
                    hist[i][c][0] = bus_EN[c];
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < 2; c++) begin
                    check($sformatf("mdl_data_i%0d_c%0d", i, c), 32'(sb[i][c*8 +: 8]), 32'(m_data[i][c]));
                    check($sformatf("mdl_pulse_i%0d_c%0d", i, c), 32'(pls[i][c]), 32'(m_pulse[i][c]));
                    check($sformatf("mdl_valid_i%0d_c%0d", i, c), 32'(vld[i][c]), 32'(m_valid[i][c]));
                    check($sformatf("mdl_ack_i%0d_c%0d", i, c), 32'(ack[i][c]),
                          32'(hist[i][c][(i == 0 ? NS_A : NS_B) - 1]));
                    check($sformatf("mdl_ovr_i%0d_c%0d", i, c), 32'(ovr[i][c]), 32'(m_ovr[i][c]));
`ifdef DATA_SYNC_PARITY_EN
                    check($sformatf("mdl_perr_i%0d_c%0d", i, c), 32'(perr[i][c]), 32'(m_perr[i][c]));
`endif
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        int cnt;
        logic seen;
        Reset = 1'b0; Async_bus = '0; bus_EN = '0; Ready = '0; Ovr_clr = '0; Async_par = '0;
        repeat (3) step();
        chk_en = 1'b1;
        check("rst_sync_bus", 32'(sb[0]), 32'h0);
        check("rst_valid", 32'(vld[0]), 32'h0);
        check("rst_ack", 32'(ack[1]), 32'h0);
        check("rst_overrun", 32'(ovr[1]), 32'h0);
        Reset = 1'b1;
        step();

        // latency: level mode, 2 stages
        Async_bus[7:0] = 8'hA5; bus_EN[0] = 1'b1;
        step();
        check("lat_ack_e1", 32'(ack[0][0]), 32'h0);
        check("lat_pulse_e1", 32'(pls[0][0]), 32'h0);
        step();
        check("lat_ack_e2", 32'(ack[0][0]), 32'h1);
        check("lat_pulse_e2", 32'(pls[0][0]), 32'h0);
        step();
        check("lat_pulse_e3", 32'(pls[0][0]), 32'h1);
        check("lat_valid_e3", 32'(vld[0][0]), 32'h1);
        check("lat_data_e3", 32'(sb[0][7:0]), 32'hA5);
        Ready[0] = 1'b1;
        step();
        check("acc_valid", 32'(vld[0][0]), 32'h0);
        check("acc_pulse", 32'(pls[0][0]), 32'h0);
        check("acc_data", 32'(sb[0][7:0]), 32'hA5);
        Ready[0] = 1'b0;
        bus_EN[0] = 1'b0;
        repeat (5) step();

        // overrun on toggle instance, channel 1
        Async_bus[15:8] = 8'h3C; bus_EN[1] = 1'b1;
        repeat (6) step();
        check("ovr_first_data", 32'(sb[1][15:8]), 32'h3C);
        check("ovr_first_valid", 32'(vld[1][1]), 32'h1);
        Async_bus[15:8] = 8'h7E; bus_EN[1] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin step(); cnt += int'(pls[1][1]); end
        check("ovr_no_pulse", 32'(cnt), 32'h0);
        check("ovr_kept_data", 32'(sb[1][15:8]), 32'h3C);
        check("ovr_flag", 32'(ovr[1][1]), 32'h1);
        Ovr_clr[1] = 1'b1;
        step();
        check("ovr_cleared", 32'(ovr[1][1]), 32'h0);

        // new overrun while clear held: set wins on that edge
        Async_bus[15:8] = 8'h11; bus_EN[1] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin step(); seen |= ovr[1][1]; end
        check("ovr_set_wins", 32'(seen), 32'h1);
        Ovr_clr[1] = 1'b0;

        // back-to-back capture on level instance, channel 0
        Async_bus[7:0] = 8'h5A; bus_EN[0] = 1'b1;
        repeat (4) step();
        check("b2b_first", 32'(sb[0][7:0]), 32'h5A);
        bus_EN[0] = 1'b0;
        step();
        Async_bus[7:0] = 8'hC3; bus_EN[0] = 1'b1;
        step();
        step();
        Ready[0] = 1'b1;
        step();
        check("b2b_pulse", 32'(pls[0][0]), 32'h1);
        check("b2b_valid", 32'(vld[0][0]), 32'h1);
        check("b2b_data", 32'(sb[0][7:0]), 32'hC3);
        check("b2b_no_ovr", 32'(ovr[0][0]), 32'h0);
        Ready[0] = 1'b0;

        // reset mid-sync; bus_EN[1] stays high across it
        bus_EN[0] = 1'b0;
        repeat (4) step();
        bus_EN[0] = 1'b1;
        step();
        Reset = 1'b0; bus_EN[0] = 1'b0;
        step();
        check("rmid_sb_a", 32'(sb[0]), 32'h0);
        check("rmid_valid_a", 32'(vld[0]), 32'h0);
        check("rmid_ack_b", 32'(ack[1]), 32'h0);
        check("rmid_ovr_b", 32'(ovr[1]), 32'h0);
        Reset = 1'b1;
        cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < 7; k++) begin step(); cnt += int'(pls[1][1]); seen |= pls[0][0]; end
        check("rmid_no_pulse", 32'(seen), 32'h0);
        check("rtog_one_pulse", 32'(cnt), 32'h1);

`ifdef DATA_SYNC_PARITY_EN
        Async_bus[7:0] = 8'h01; Async_par[0] = 1'b0; bus_EN[0] = 1'b1;
        repeat (4) step();
        check("par_err_set", 32'(perr[0][0]), 32'h1);
        check("par_data", 32'(sb[0][7:0]), 32'h01);
        Ready[0] = 1'b1;
        step();
        Ready[0] = 1'b0; bus_EN[0] = 1'b0;
        step();
        Async_bus[7:0] = 8'h03; bus_EN[0] = 1'b1;
        repeat (4) step();
        check("par_err_clr", 32'(perr[0][0]), 32'h0);
        check("par_data2", 32'(sb[0][7:0]), 32'h03);
`endif

        repeat (3) step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
